lif_scan_core: RTL

Time-multiplexed leaky integrate-and-fire engine that holds membrane state for `NUM_NEURONS` neurons. On each timestep tick it scans every neuron once: it integrates the input current, applies leak, compares against threshold, and writes a spike event for each firing neuron into the downstream spike-event FIFO. The event FIFO uses an active-low push and drives a `full` flag. The block is the producer that feeds that FIFO, and it stalls the scan on back-pressure so that no event is lost.

---
 rtl/neuron_pkg.sv | 46 ++++
 rtl/lif_update.sv | 70 +++++++
 rtl/lif_scan_core.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : neuron_pkg
//  Description : Shared types and helpers for the LIF scan engine.
//                - scan_state_t : scan FSM encoding (IDLE / SCAN / DRAIN)
//                - spike_evt_t  : spike event word {ts, idx}
//                - sat_v        : clamp a widened potential into V range
//                The PKG_* widths are the build widths of the event word and
//                the membrane potential; top-level parameters default to them.
//  Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

    localparam int PKG_NEURON_ADDR = 4;
    localparam int PKG_TS_WIDTH    = 4;
    localparam int PKG_V_WIDTH     = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic [PKG_TS_WIDTH-1:0]    ts;
        logic [PKG_NEURON_ADDR-1:0] idx;
    } spike_evt_t;

    // The sum carries two guard bits. If the top three bits agree the value
    // already fits; otherwise the sign bit picks which rail to clamp to.
    function automatic logic signed [PKG_V_WIDTH-1:0] sat_v(
        input logic signed [PKG_V_WIDTH+1:0] x
    );
        logic [2:0] top;
        top = x[PKG_V_WIDTH+1:PKG_V_WIDTH-1];
        if (top == 3'b000 || top == 3'b111) begin
            sat_v = x[PKG_V_WIDTH-1:0];
        end else if (x[PKG_V_WIDTH+1]) begin
            sat_v = {1'b1, {(PKG_V_WIDTH-1){1'b0}}};
        end else begin
            sat_v = {1'b0, {(PKG_V_WIDTH-1){1'b1}}};
        end
    endfunction

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/lif_update.sv
`default_nettype none
// ============================================================================
//  Module      : lif_update
//  Description : Combinational single-neuron leaky integrate-and-fire step.
//                v_next = sat(v - (v >>> LEAK_SHIFT) + i_data); fires when
//                v_next >= THRESHOLD, in which case the potential resets.
//                Optional macro LIF_REFRACTORY_EN adds the refractory count
//                ports (refr / refr_next); while counting, input is ignored.
//  Ports       : v (in), refr (in, macro), i_data (in),
//                v_next (out), refr_next (out, macro), spike (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_update
    import neuron_pkg::*;
#(
    parameter int V_WIDTH    = PKG_V_WIDTH,
    parameter int I_WIDTH    = 16,
    parameter int THRESHOLD  = 1000,
    parameter int V_RESET    = 0,
    parameter int LEAK_SHIFT = 4
`ifdef LIF_REFRACTORY_EN
    ,
    parameter int REFRACT    = 2,
    parameter int REFR_W     = 2
`endif
) (
    input  logic signed [V_WIDTH-1:0] v,
`ifdef LIF_REFRACTORY_EN
    input  logic        [REFR_W-1:0]  refr,
    output logic        [REFR_W-1:0]  refr_next,
`endif
    input  logic signed [I_WIDTH-1:0] i_data,
    output logic signed [V_WIDTH-1:0] v_next,
    output logic                      spike
);

    localparam int                        c_sum_w     = V_WIDTH + 2;
    localparam logic signed [V_WIDTH-1:0] c_threshold = V_WIDTH'(THRESHOLD);
    localparam logic signed [V_WIDTH-1:0] c_v_reset   = V_WIDTH'(V_RESET);

    logic signed [V_WIDTH-1:0] w_leak;
    logic signed [c_sum_w-1:0] w_v_ext;
    logic signed [c_sum_w-1:0] w_leak_ext;
    logic signed [c_sum_w-1:0] w_i_ext;
    logic signed [c_sum_w-1:0] w_sum;
    logic signed [V_WIDTH-1:0] w_v_sat;
    logic                      w_fire;

    assign w_leak     = v >>> LEAK_SHIFT;
    assign w_v_ext    = {{2{v[V_WIDTH-1]}}, v};
    assign w_leak_ext = {{2{w_leak[V_WIDTH-1]}}, w_leak};
    assign w_i_ext    = {{(c_sum_w-I_WIDTH){i_data[I_WIDTH-1]}}, i_data};
    assign w_sum      = w_v_ext - w_leak_ext + w_i_ext;
    assign w_v_sat    = sat_v(w_sum);
    assign w_fire     = (w_v_sat >= c_threshold);

`ifdef LIF_REFRACTORY_EN
    logic w_refractory;
    assign w_refractory = (refr != '0);
    assign spike        = w_fire && !w_refractory;
    assign v_next       = (w_refractory || w_fire) ? c_v_reset : w_v_sat;
    assign refr_next    = w_refractory ? (refr - REFR_W'(1))
                        : (w_fire ? REFR_W'(REFRACT) : '0);
`else
    assign spike  = w_fire;
    assign v_next = w_fire ? c_v_reset : w_v_sat;
`endif

endmodule : lif_update
`default_nettype wire

// File: rtl/lif_scan_core.sv
`default_nettype none
// ============================================================================
//  Module      : lif_scan_core
//  Description : Time-multiplexed LIF engine. Each tick scans all neurons
//                once through lif_update and pushes one {timestep, idx} event
//                per spike into a downstream FIFO (active-low push). A single
//                event register holds the pending event; while it is blocked
//                by `full` the scan freezes so no event is ever dropped.
//                Optional macro LIF_REFRACTORY_EN adds per-neuron refractory
//                counters.
//  Ports       : clk, rst_n (async, active low), tick, i_addr/i_data (current
//                lookup, combinational), full, push_req_n, evt_data, busy,
//                done, timestep, tick_overrun
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_scan_core
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int NEURON_ADDR = PKG_NEURON_ADDR,
    parameter int TS_WIDTH    = PKG_TS_WIDTH,
    parameter int V_WIDTH     = PKG_V_WIDTH,
    parameter int I_WIDTH     = 16,
    parameter int THRESHOLD   = 1000,
    parameter int V_RESET     = 0,
    parameter int LEAK_SHIFT  = 4,
    parameter int REFRACT     = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tick,
    output logic [NEURON_ADDR-1:0]          i_addr,
    input  logic [I_WIDTH-1:0]              i_data,
    input  logic                            full,
    output logic                            push_req_n,
    output logic [TS_WIDTH+NEURON_ADDR-1:0] evt_data,
    output logic                            busy,
    output logic                            done,
    output logic [TS_WIDTH-1:0]             timestep,
    output logic                            tick_overrun
);

    localparam logic signed [V_WIDTH-1:0]   c_v_reset  = V_WIDTH'(V_RESET);
    localparam logic [NEURON_ADDR-1:0]      c_last_idx = NEURON_ADDR'(NUM_NEURONS - 1);

    scan_state_t                state_q, state_d;
    logic [NEURON_ADDR-1:0]     idx_q, idx_d;
    logic [TS_WIDTH-1:0]        ts_q, ts_d;
    logic                       evt_valid_q, evt_valid_d;
    spike_evt_t                 evt_q, evt_d;
    logic                       overrun_q, overrun_d;
    logic signed [V_WIDTH-1:0]  v_q [NUM_NEURONS];
    logic signed [V_WIDTH-1:0]  v_d [NUM_NEURONS];

    logic signed [V_WIDTH-1:0]  w_v_cur;
    logic signed [V_WIDTH-1:0]  w_v_next;
    logic                       w_spike;
    logic                       w_stall;
    logic                       w_proc;

`ifdef LIF_REFRACTORY_EN
    localparam int c_refr_w = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    logic [c_refr_w-1:0] refr_q [NUM_NEURONS];
    logic [c_refr_w-1:0] refr_d [NUM_NEURONS];
    logic [c_refr_w-1:0] w_refr_next;
`endif

    // A pending event that the FIFO refuses freezes the whole scan.
    assign w_stall = evt_valid_q && full;
    assign w_proc  = (state_q == S_SCAN) && !w_stall;
    assign w_v_cur = v_q[idx_q];

    lif_update #(
        .V_WIDTH    (V_WIDTH),
        .I_WIDTH    (I_WIDTH),
        .THRESHOLD  (THRESHOLD),
        .V_RESET    (V_RESET),
        .LEAK_SHIFT (LEAK_SHIFT)
`ifdef LIF_REFRACTORY_EN
        ,
        .REFRACT    (REFRACT),
        .REFR_W     (c_refr_w)
`endif
    ) u_lif_update (
        .v          (w_v_cur),
`ifdef LIF_REFRACTORY_EN
        .refr       (refr_q[idx_q]),
        .refr_next  (w_refr_next),
`endif
        .i_data     ($signed(i_data)),
        .v_next     (w_v_next),
        .spike      (w_spike)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ts_d        = ts_q;
        evt_valid_d = evt_valid_q;
        evt_d       = evt_q;
        overrun_d   = overrun_q;
        v_d         = v_q;
`ifdef LIF_REFRACTORY_EN
        refr_d      = refr_q;
`endif

        if (tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (w_proc) begin
                    v_d[idx_q] = w_v_next;
`ifdef LIF_REFRACTORY_EN
                    refr_d[idx_q] = w_refr_next;
`endif
                    // Not stalled: any pending event is accepted this edge,
                    // so the register is free for this neuron's spike.
                    evt_valid_d = w_spike;
                    if (w_spike) begin
                        evt_d.ts  = ts_q;
                        evt_d.idx = idx_q;
                    end
                    // Wraps back to 0 after the last neuron.
                    idx_d = idx_q + NEURON_ADDR'(1);
                    if (idx_q == c_last_idx) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!w_stall) begin
                    evt_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    ts_d        = ts_q + TS_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            ts_q        <= '0;
            evt_valid_q <= 1'b0;
            evt_q       <= '0;
            overrun_q   <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                v_q[n] <= c_v_reset;
`ifdef LIF_REFRACTORY_EN
                refr_q[n] <= '0;
`endif
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ts_q        <= ts_d;
            evt_valid_q <= evt_valid_d;
            evt_q       <= evt_d;
            overrun_q   <= overrun_d;
            v_q         <= v_d;
`ifdef LIF_REFRACTORY_EN
            refr_q      <= refr_d;
`endif
        end
    end

    assign i_addr       = idx_q;
    assign push_req_n   = !evt_valid_q;
    assign evt_data     = evt_q;
    assign busy         = (state_q != S_IDLE);
    // The timestep closes in the DRAIN cycle whose event (if any) leaves.
    assign done         = (state_q == S_DRAIN) && !w_stall;
    assign timestep     = ts_q;
    assign tick_overrun = overrun_q;

endmodule : lif_scan_core
`default_nettype wire
